// File: rtl/seg_pkg.sv
// Shared codes for the 7-segment receive path.
// Active-low segment patterns, select codes and frame FSM states.
package seg_pkg;

  localparam logic [7:0] SEG_NUM0 = 8'hC0;
  localparam logic [7:0] SEG_NUM1 = 8'hF9;
  localparam logic [7:0] SEG_NUM2 = 8'hA4;
  localparam logic [7:0] SEG_NUM3 = 8'hB0;
  localparam logic [7:0] SEG_NUM4 = 8'h99;
  localparam logic [7:0] SEG_NUM5 = 8'h92;
  localparam logic [7:0] SEG_NUM6 = 8'h82;
  localparam logic [7:0] SEG_NUM7 = 8'hF8;
  localparam logic [7:0] SEG_NUM8 = 8'h80;
  localparam logic [7:0] SEG_NUM9 = 8'h90;
  localparam logic [7:0] SEG_NONE = 8'hFF;

  localparam logic [3:0] SEL_D0 = 4'b1110;
  localparam logic [3:0] SEL_D1 = 4'b1101;
  localparam logic [3:0] SEL_D2 = 4'b1011;
  localparam logic [3:0] SEL_D3 = 4'b0111;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_ERR   = 4'hE;

  typedef enum logic {
    IDLE,
    COLLECT
  } frame_state_e;

endpackage

// File: rtl/seg_code_decode.sv
// Combinational 8-bit active-low segment pattern to digit value.
// Unknown patterns return DIG_ERR with err set.
module seg_code_decode
  import seg_pkg::*;
(
  input  logic [7:0] pat,
  output logic       err,
  output logic [3:0] val
);

  // Lookup of the ten digit glyphs plus blank
  always_comb begin
    err = 1'b0;
    val = DIG_ERR;
    case (pat)
      SEG_NUM0: val = 4'd0;
      SEG_NUM1: val = 4'd1;
      SEG_NUM2: val = 4'd2;
      SEG_NUM3: val = 4'd3;
      SEG_NUM4: val = 4'd4;
      SEG_NUM5: val = 4'd5;
      SEG_NUM6: val = 4'd6;
      SEG_NUM7: val = 4'd7;
      SEG_NUM8: val = 4'd8;
      SEG_NUM9: val = 4'd9;
      SEG_NONE: val = DIG_BLANK;
      default:  err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_decoder.sv
// Receive side of a 4-digit multiplexed 7-segment bus: sync, debounce,
// decode and frame assembly. SEG_DP_EN adds a decoded dp[3:0] output.
module seg_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic [3:0]  sel_in,
  input  logic [7:0]  seg_in,
  output logic [15:0] digits,
  output logic        frame_vld,
  output logic        code_err,
  output logic        sel_err,
`ifdef SEG_DP_EN
  output logic [3:0]  dp,
`endif
  output logic        stale
);

  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [3:0]  sel_s1_q, sel_s2_q;
  logic [7:0]  seg_s1_q, seg_s2_q;
  logic [SW-1:0] stab_q, stab_d;
  logic [TW-1:0] to_q, to_d;
  frame_state_e state_q, state_d;
  logic [1:0]  exp_q, exp_d;
  logic [3:0][3:0] sh_q, sh_d;
  logic [15:0] digits_q, digits_d;
  logic        frame_vld_q, frame_vld_d;
  logic        code_err_q, code_err_d;
  logic        sel_err_q, sel_err_d;
  logic        stale_q, stale_d;
  logic [3:0]  dps_q, dps_d;
  logic [3:0]  dp_q, dp_d;

  logic        chg, cap, vcap, to_hit;
  logic        sel_ok;
  logic [1:0]  idx;
  logic [7:0]  dec_pat;
  logic        dec_err;
  logic [3:0]  dec_val;
  logic        dp_bit;

`ifdef SEG_DP_EN
  assign dec_pat = {1'b1, seg_s2_q[6:0]};
`else
  assign dec_pat = seg_s2_q;
`endif
  assign dp_bit = ~seg_s2_q[7];

  seg_code_decode u_dec (
    .pat (dec_pat),
    .err (dec_err),
    .val (dec_val)
  );

  // Two-flop synchronizer on the whole bus
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      sel_s1_q <= 4'hF;
      sel_s2_q <= 4'hF;
      seg_s1_q <= 8'hFF;
      seg_s2_q <= 8'hFF;
    end else begin
      sel_s1_q <= sel_in;
      sel_s2_q <= sel_s1_q;
      seg_s1_q <= seg_in;
      seg_s2_q <= seg_s1_q;
    end
  end

  // Slot index from the one-hot-low select
  always_comb begin
    sel_ok = 1'b1;
    idx    = 2'd0;
    unique case (1'b1)
      (sel_s2_q == SEL_D0): idx = 2'd0;
      (sel_s2_q == SEL_D1): idx = 2'd1;
      (sel_s2_q == SEL_D2): idx = 2'd2;
      (sel_s2_q == SEL_D3): idx = 2'd3;
      default:              sel_ok = 1'b0;
    endcase
  end

  // Stability and timeout counters, capture strobes
  always_comb begin
    chg = {sel_s1_q, seg_s1_q} != {sel_s2_q, seg_s2_q};
    cap = stab_q == SW'(STABLE_CYC - 1);
    vcap = cap & sel_ok;
    if (chg)
      stab_d = '0;
    else if (stab_q != SW'(STABLE_CYC))
      stab_d = stab_q + SW'(1);
    else
      stab_d = stab_q;
    to_hit = !vcap && (to_q == TW'(TIMEOUT_CYC - 1));
    if (vcap)
      to_d = '0;
    else if (to_q != TW'(TIMEOUT_CYC))
      to_d = to_q + TW'(1);
    else
      to_d = to_q;
  end

  // Frame FSM: next state, shadow writes and output pulses
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    sh_d        = sh_q;
    dps_d       = dps_q;
    digits_d    = digits_q;
    dp_d        = dp_q;
    frame_vld_d = 1'b0;
    code_err_d  = vcap & dec_err;
    sel_err_d   = cap & ~sel_ok;
    stale_d     = stale_q;
    if (vcap) begin
      unique case (state_q)
        IDLE: begin
          if (idx == 2'd0) begin
            sh_d[0]  = dec_val;
            dps_d[0] = dp_bit;
            exp_d    = 2'd1;
            state_d  = COLLECT;
          end
        end
        COLLECT: begin
          if (idx == exp_q) begin
            sh_d[idx]  = dec_val;
            dps_d[idx] = dp_bit;
            exp_d      = exp_q + 2'd1;
            if (idx == 2'd3) begin
              digits_d    = {dec_val, sh_q[2], sh_q[1], sh_q[0]};
              dp_d        = {dp_bit, dps_q[2:0]};
              frame_vld_d = 1'b1;
              state_d     = IDLE;
            end
          end else if (idx == 2'd0) begin
            sh_d[0]  = dec_val;
            dps_d[0] = dp_bit;
            exp_d    = 2'd1;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (to_hit) begin
      stale_d = 1'b1;
      state_d = IDLE;
    end
    if (frame_vld_d)
      stale_d = 1'b0;
  end

  // State and output registers
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      stab_q      <= '0;
      to_q        <= '0;
      state_q     <= IDLE;
      exp_q       <= 2'd0;
      sh_q        <= '0;
      dps_q       <= 4'h0;
      digits_q    <= 16'hFFFF;
      dp_q        <= 4'h0;
      frame_vld_q <= 1'b0;
      code_err_q  <= 1'b0;
      sel_err_q   <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      stab_q      <= stab_d;
      to_q        <= to_d;
      state_q     <= state_d;
      exp_q       <= exp_d;
      sh_q        <= sh_d;
      dps_q       <= dps_d;
      digits_q    <= digits_d;
      dp_q        <= dp_d;
      frame_vld_q <= frame_vld_d;
      code_err_q  <= code_err_d;
      sel_err_q   <= sel_err_d;
      stale_q     <= stale_d;
    end
  end

  assign digits    = digits_q;
  assign frame_vld = frame_vld_q;
  assign code_err  = code_err_q;
  assign sel_err   = sel_err_q;
  assign stale     = stale_q;
`ifdef SEG_DP_EN
  assign dp        = dp_q;
`else
  logic unused_dp;
  assign unused_dp = ^{dp_q, dp_bit};
`endif

endmodule

// File: tb/tb_seg_decoder.sv
// Bench for seg_decoder: directed slot sequences, frames checked
// by a monitor against a queue of expected digit words.
module tb_seg_decoder;
  import seg_pkg::*;

  localparam int S   = 16;
  localparam int T   = 400;
  localparam int SL  = 40;

  logic        sclk;
  logic        s_rst_n;
  logic [3:0]  sel_in;
  logic [7:0]  seg_in;
  logic [15:0] digits;
  logic        frame_vld;
  logic        code_err;
  logic        sel_err;
  logic        stale;
`ifdef SEG_DP_EN
  logic [3:0]  dp;
`endif

  int tests;
  int fails;
  int n_code;
  int n_sel;
  int n_frames;
  logic [15:0] exp_q[$];

  seg_decoder #(
    .STABLE_CYC  (S),
    .TIMEOUT_CYC (T)
  ) dut (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .sel_in    (sel_in),
    .seg_in    (seg_in),
    .digits    (digits),
    .frame_vld (frame_vld),
    .code_err  (code_err),
    .sel_err   (sel_err),
`ifdef SEG_DP_EN
    .dp        (dp),
`endif
    .stale     (stale)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic slot(input logic [3:0] s, input logic [7:0] g,
                      input int n);
    sel_in = s;
    seg_in = g;
    repeat (n) @(posedge sclk);
  endtask

  task automatic frame(input logic [7:0] g0, input logic [7:0] g1,
                       input logic [7:0] g2, input logic [7:0] g3);
    slot(SEL_D0, g0, SL);
    slot(SEL_D1, g1, SL);
    slot(SEL_D2, g2, SL);
    slot(SEL_D3, g3, SL);
  endtask

  // Monitor: pop expected frame on each frame_vld, count pulses
  always @(negedge sclk) begin
    if (s_rst_n) begin
      if (frame_vld) begin
        n_frames++;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", {16'h0, digits}, 32'hDEAD);
        end else begin
          chk("frame_digits", {16'h0, digits}, {16'h0, exp_q.pop_front()});
        end
        chk("stale_on_frame", {31'h0, stale}, 32'h0);
      end
      if (code_err) n_code++;
      if (sel_err) n_sel++;
    end
  end

  initial begin
    tests = 0; fails = 0; n_code = 0; n_sel = 0; n_frames = 0;
    s_rst_n = 1'b0;
    sel_in = SEL_D3;
    seg_in = SEG_NUM3;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    chk("rst_digits", {16'h0, digits}, 32'hFFFF);
    chk("rst_frame_vld", {31'h0, frame_vld}, 32'h0);
    chk("rst_code_err", {31'h0, code_err}, 32'h0);
    chk("rst_sel_err", {31'h0, sel_err}, 32'h0);
    chk("rst_stale", {31'h0, stale}, 32'h0);
    s_rst_n = 1'b1;
    @(posedge sclk);
    slot(SEL_D3, SEG_NUM3, SL);

    // normal cyclic 1,3,0,3
    repeat (3) begin
      exp_q.push_back(16'h3031);
      frame(SEG_NUM1, SEG_NUM3, SEG_NUM0, SEG_NUM3);
    end
    chk("normal_code_err", n_code, 0);
    chk("normal_sel_err", n_sel, 0);

    // short glitch on digit 2 must not be captured
    exp_q.push_back(16'h3031);
    slot(SEL_D0, SEG_NUM1, SL);
    slot(SEL_D1, SEG_NUM3, SL);
    slot(SEL_D2, SEG_NUM8, S - 4);
    slot(SEL_D2, SEG_NUM0, SL);
    slot(SEL_D3, SEG_NUM3, SL);
    @(negedge sclk);
    chk("glitch_digits", {16'h0, digits}, 32'h3031);

    // bad code on digit 2
    exp_q.push_back(16'h7E77);
    frame(SEG_NUM7, SEG_NUM7, 8'hAA, SEG_NUM7);
    chk("bad_code_cnt", n_code, 1);

    // multi-low select then a recovering sequence
    slot(4'b1100, SEG_NUM7, SL);
    chk("sel_err_cnt", n_sel, 1);
    chk("sel_err_no_frame", n_frames, 5);
    exp_q.push_back(16'h9865);
    slot(SEL_D1, SEG_NUM2, SL);
    slot(SEL_D0, SEG_NUM5, SL);
    slot(SEL_D1, SEG_NUM6, SL);
    slot(SEL_D2, SEG_NUM8, SL);
    slot(SEL_D3, SEG_NUM9, SL);
    @(negedge sclk);
    chk("recover_frames", n_frames, 6);
    chk("pre_freeze_stale", {31'h0, stale}, 32'h0);

    // frozen bus then resume with blanks
    slot(SEL_D3, SEG_NUM9, T + 20);
    @(negedge sclk);
    chk("freeze_stale", {31'h0, stale}, 32'h1);
    exp_q.push_back(16'hF0F4);
    frame(SEG_NUM4, SEG_NONE, SEG_NUM0, SEG_NONE);
    @(negedge sclk);
    chk("resume_stale", {31'h0, stale}, 32'h0);
    chk("resume_digits", {16'h0, digits}, 32'hF0F4);

    // reset after digit 1 capture
    slot(SEL_D0, SEG_NUM1, SL);
    slot(SEL_D1, SEG_NUM3, SL);
    slot(SEL_D2, SEG_NUM0, 10);
    s_rst_n = 1'b0;
    repeat (2) @(posedge sclk);
    @(negedge sclk);
    chk("mid_rst_digits", {16'h0, digits}, 32'hFFFF);
    chk("mid_rst_frame_vld", {31'h0, frame_vld}, 32'h0);
    chk("mid_rst_code_err", {31'h0, code_err}, 32'h0);
    chk("mid_rst_sel_err", {31'h0, sel_err}, 32'h0);
    s_rst_n = 1'b1;
    slot(SEL_D2, SEG_NUM0, SL);
    slot(SEL_D3, SEG_NUM3, SL);
    chk("post_rst_no_frame", n_frames, 7);
    exp_q.push_back(16'h3031);
    frame(SEG_NUM1, SEG_NUM3, SEG_NUM0, SEG_NUM3);
    repeat (10) @(posedge sclk);

    chk("total_frames", n_frames, 8);
    chk("queue_empty", exp_q.size(), 0);
    chk("total_code_err", n_code, 1);
    chk("total_sel_err", n_sel, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
